warp_fetcher: RTL

- Instruction-fetch stage that sits directly upstream of the core scheduler.
- Serves up to NUM_WARPS warps that share one program-memory read channel.
- Keeps one slot per warp (state, PC, instruction), so an in-flight or completed fetch survives a warp switch.
- Presents fetcher_state and instruction for the warp currently selected by the scheduler.

---
 rtl/warp_fetcher.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/warp_fetcher.sv
`default_nettype none
// ============================================================================
//  Module   : warp_fetcher
//  Purpose  : Instruction-fetch stage shared by NUM_WARPS warps. Each warp owns
//             a slot (state + instruction) so a fetch in flight or completed
//             survives a scheduler warp switch. A single program-memory read
//             channel carries at most one outstanding request.
//  Optional : FETCHER_REUSE_EN - when defined, each slot remembers the PC of
//             its last captured instruction; a FETCH for that same PC
//             completes in one cycle without touching program memory.
//  Ports    : clk, reset            - clock / synchronous active-high reset
//             core_state            - scheduler state (FETCH=001, DECODE=010)
//             warp_select           - active warp index
//             current_pc            - PC of the active warp
//             mem_read_valid/_address/_ready/_data - program-memory channel
//             fetcher_state         - slot state of selected warp
//             instruction           - instruction held by selected warp
//  Revision : 1.0 - initial release
// ============================================================================
module warp_fetcher #(
    parameter int NUM_WARPS             = 2,
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int SEL_W                 = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [SEL_W-1:0]                 warp_select,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);

    localparam logic [2:0] c_CORE_FETCH  = 3'b001;
    localparam logic [2:0] c_CORE_DECODE = 3'b010;

    localparam logic [2:0] c_ST_IDLE     = 3'b000;
    localparam logic [2:0] c_ST_FETCHING = 3'b001;
    localparam logic [2:0] c_ST_FETCHED  = 3'b010;

    // Per-slot state
    logic [2:0]                       state_q [NUM_WARPS];
    logic [2:0]                       state_d [NUM_WARPS];
    logic [PROGRAM_MEM_DATA_BITS-1:0] instr_q [NUM_WARPS];
    logic [PROGRAM_MEM_DATA_BITS-1:0] instr_d [NUM_WARPS];

`ifdef FETCHER_REUSE_EN
    logic [PROGRAM_MEM_ADDR_BITS-1:0] last_pc_q [NUM_WARPS];
    logic [PROGRAM_MEM_ADDR_BITS-1:0] last_pc_d [NUM_WARPS];
    logic                             hit_valid_q [NUM_WARPS];
    logic                             hit_valid_d [NUM_WARPS];
`endif

    // Shared channel state; the channel is busy exactly while valid is high
    logic                             valid_q, valid_d;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] addr_q,  addr_d;
    logic [SEL_W-1:0]                 owner_q, owner_d;

    // One-hot decode of warp_select; out-of-range selects match no slot
    logic [NUM_WARPS-1:0] w_sel_hot;
    logic                 w_capture;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WARPS; gi++) begin : g_sel
            assign w_sel_hot[gi] = (warp_select == SEL_W'(gi));
        end
    endgenerate

    assign w_capture = valid_q & mem_read_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            owner_q <= '0;
            for (int i = 0; i < NUM_WARPS; i++) begin
                state_q[i] <= c_ST_IDLE;
                instr_q[i] <= '0;
`ifdef FETCHER_REUSE_EN
                last_pc_q[i]   <= '0;
                hit_valid_q[i] <= 1'b0;
`endif
            end
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            owner_q <= owner_d;
            for (int i = 0; i < NUM_WARPS; i++) begin
                state_q[i] <= state_d[i];
                instr_q[i] <= instr_d[i];
`ifdef FETCHER_REUSE_EN
                last_pc_q[i]   <= last_pc_d[i];
                hit_valid_q[i] <= hit_valid_d[i];
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        owner_d = owner_q;

        // Response frees the channel; a new issue may then happen the cycle
        // after, leaving one idle bus cycle between requests.
        if (w_capture) begin
            valid_d = 1'b0;
        end

        for (int i = 0; i < NUM_WARPS; i++) begin
            state_d[i] = state_q[i];
            instr_d[i] = instr_q[i];
`ifdef FETCHER_REUSE_EN
            last_pc_d[i]   = last_pc_q[i];
            hit_valid_d[i] = hit_valid_q[i];
`endif
            case (state_q[i])
                c_ST_IDLE: begin
                    if (core_state == c_CORE_FETCH && w_sel_hot[i]) begin
`ifdef FETCHER_REUSE_EN
                        // Reuse hit bypasses the channel, so it works even
                        // while another warp's request is outstanding.
                        if (hit_valid_q[i] && current_pc == last_pc_q[i]) begin
                            state_d[i] = c_ST_FETCHED;
                        end else
`endif
                        if (!valid_q) begin
                            state_d[i] = c_ST_FETCHING;
                            valid_d    = 1'b1;
                            addr_d     = current_pc;
                            owner_d    = SEL_W'(i);
                        end
                    end
                end
                c_ST_FETCHING: begin
                    if (w_capture && owner_q == SEL_W'(i)) begin
                        state_d[i] = c_ST_FETCHED;
                        instr_d[i] = mem_read_data;
`ifdef FETCHER_REUSE_EN
                        last_pc_d[i]   = addr_q;
                        hit_valid_d[i] = 1'b1;
`endif
                    end
                end
                c_ST_FETCHED: begin
                    if (core_state == c_CORE_DECODE && w_sel_hot[i]) begin
                        state_d[i] = c_ST_IDLE;
                    end
                end
                default: begin
                    state_d[i] = c_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic: selected-slot mux, zero when warp_select is out of range
    // ------------------------------------------------------------------
    always_comb begin
        fetcher_state = c_ST_IDLE;
        instruction   = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            if (w_sel_hot[i]) begin
                fetcher_state = state_q[i];
                instruction   = instr_q[i];
            end
        end
    end

    assign mem_read_valid   = valid_q;
    assign mem_read_address = addr_q;

endmodule
`default_nettype wire
